pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Central sequencer for the 5-stage IF/ID/EX/MEM/WB pipeline.
- Decides each cycle whether the PC and IF/ID register load, whether IF/ID is flushed, and whether a bubble is injected into ID/EX.
- Freezes the whole pipeline while data memory is busy.
- Keeps a small FSM for multi-cycle load-use stalls and memory waits, plus saturating event counters for debug.

Parameters:
- LOAD_STALL_CYCLES, 1: total stall cycles per load-use hazard (1..7).
- MEM_TIMEOUT, 64: max MEM_WAIT cycles before abort (2..255).
- CNT_W, 16: width of statistics counters.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; 0 = reset.
- id_rs  input  5  rs field of instruction in ID.
- id_rt  input  5  rt field of instruction in ID.
- id_uses_rs  input  1  ID instruction reads rs.
- id_uses_rt  input  1  ID instruction reads rt.
- ex_mem_read  input  1  instruction in EX is a load.
- ex_rw  input  5  destination register of EX instruction.
- branch_taken  input  1  control transfer in EX resolved taken this cycle.
- dmem_req  input  1  MEM stage is issuing a data memory access.
- dmem_ready  input  1  data memory completes the access this cycle.
- pc_le  output  1  PC load enable.
- if_id_le  output  1  drives IF/ID load_enable.
- if_id_flush  output  1  drives IF/ID control_hazard_reset.
- id_ex_bubble  output  1  forces ID/EX control-signal input to 0.
- pipe_en  output  1  clock enable for ID/EX, EX/MEM, MEM/WB.
- stall_count  output  CNT_W  cycles with pc_le=0 since reset, saturating.
- flush_count  output  CNT_W  if_id_flush cycles since reset, saturating.
- mem_timeout_err  output  1  sticky; set when MEM_TIMEOUT expires.

Behaviour:
- load_use is asserted when all of the following hold:
  - ex_mem_read=1.
  - ex_rw != 0.
  - (id_uses_rs and id_rs==ex_rw) or (id_uses_rt and id_rt==ex_rw).
- mem_busy = dmem_req and not dmem_ready.
- FSM states: RUN, LOAD_STALL, MEM_WAIT. The state register and a 3-bit stall counter are used. The timeout counter is 8 bits. All are cleared asynchronously by reset.
- Outputs are Mealy (combinational from state and inputs), with zero added latency.
- Default outputs: pc_le=1, if_id_le=1, if_id_flush=0, id_ex_bubble=0, pipe_en=1.
- Input priority in RUN: mem_busy > branch_taken > load_use.
- RUN with mem_busy:
  - Outputs: pc_le=0, if_id_le=0, pipe_en=0, id_ex_bubble=0.
  - Next state MEM_WAIT; timeout counter set to 1.
- RUN with branch_taken (no mem_busy):
  - Outputs: if_id_flush=1, id_ex_bubble=1, pc_le=1 (PC takes target).
  - Any load_use in the same cycle is ignored; flush_count increments. State stays RUN.
- RUN with load_use only:
  - Outputs: pc_le=0, if_id_le=0, id_ex_bubble=1, pipe_en=1.
  - If LOAD_STALL_CYCLES>1: next state LOAD_STALL, stall counter = LOAD_STALL_CYCLES-1. Otherwise stay in RUN.
- LOAD_STALL:
  - Same outputs as the RUN load_use case; stall counter decrements each cycle.
  - Returns to RUN in the cycle after the counter reaches 1, so the total stall is exactly LOAD_STALL_CYCLES cycles.
  - mem_busy in LOAD_STALL takes priority: go to MEM_WAIT and abandon the remaining stall (the bubble already sits in EX).
  - branch_taken cannot occur here (EX holds a bubble). If asserted anyway, it is handled as in RUN and the FSM returns to RUN.
- MEM_WAIT:
  - Outputs: pc_le=0, if_id_le=0, pipe_en=0, if_id_flush=0, id_ex_bubble=0. branch_taken and load_use are ignored because the inputs are frozen.
  - Exit when dmem_ready=1: outputs return to defaults that cycle and next state is RUN. If load_use or branch_taken is asserted in the exit cycle, the RUN rules apply in that same cycle.
  - Timeout counter increments each cycle in this state. When it reaches MEM_TIMEOUT without dmem_ready: set mem_timeout_err, release the pipeline that cycle (defaults), and go to RUN.
- mem_timeout_err stays set until reset.
- Counters:
  - stall_count increments each cycle with pc_le=0.
  - flush_count increments each cycle with if_id_flush=1.
  - Both saturate at all-ones and do not wrap.
- While reset=0:
  - Outputs: pc_le=0, if_id_le=0, if_id_flush=0, id_ex_bubble=1, pipe_en=0.
  - Counters and mem_timeout_err are 0; state is RUN.
- Reset asserted mid-stall or mid-wait aborts immediately. After reset deasserts, the first clock edge is in RUN.

Test Plan:
- Load-use: ex_mem_read=1, ex_rw=8, id_rs=8, id_uses_rs=1 for 1 cycle -> that cycle pc_le=0, if_id_le=0, id_ex_bubble=1; next cycle defaults; stall_count=1.
- ex_rw=0 with id_rs=0, ex_mem_read=1 -> no stall, outputs default. Same with id_uses_rt=0 and id_rt==ex_rw -> no stall.
- LOAD_STALL_CYCLES=3, one load_use pulse -> pc_le=0 for exactly 3 consecutive cycles, then 1; stall_count=3.
- branch_taken and load_use in the same cycle -> if_id_flush=1, id_ex_bubble=1, pc_le=1; flush_count=1; stall_count unchanged.
- dmem_req=1 with dmem_ready low for 5 cycles then high -> pipe_en=0 and pc_le=0 for 5 cycles; pipe_en=1 in the ready cycle; stall_count=5; branch_taken pulsed during the wait is ignored.
- MEM_TIMEOUT=4, dmem_ready held 0 -> after 4 MEM_WAIT cycles mem_timeout_err=1 and the pipeline releases; assert reset=0 mid-wait in a second run -> all outputs take reset values immediately and counters are 0.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_controller
// Purpose : Stall/flush/freeze sequencer for the 5-stage IF/ID/EX/MEM/WB core.
// Revision: 1.0  initial release
// ============================================================================
module pipeline_hazard_controller #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 64,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rw,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_le,
    output logic             if_id_le,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_en,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout_err
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2
    } state_t;

    localparam logic [2:0]       c_STALL_INIT   = 3'(LOAD_STALL_CYCLES - 1);
    localparam bit               c_MULTI_STALL  = (LOAD_STALL_CYCLES > 1);
    localparam logic [7:0]       c_TIMEOUT      = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] c_CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE      = CNT_W'(1);

    state_t           state_q, state_d;
    logic [2:0]       stall_cnt_q, stall_cnt_d;
    logic [7:0]       tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             err_q, err_d;

    logic w_load_use;
    logic w_mem_busy;
    logic w_run_rules;
    logic w_pc_le, w_if_id_le, w_flush, w_bubble, w_pipe_en;

    assign w_load_use = ex_mem_read && (ex_rw != 5'd0) &&
                        ((id_uses_rs && (id_rs == ex_rw)) ||
                         (id_uses_rt && (id_rt == ex_rw)));
    assign w_mem_busy = dmem_req && !dmem_ready;

    always_comb begin
        w_pc_le     = 1'b1;
        w_if_id_le  = 1'b1;
        w_flush     = 1'b0;
        w_bubble    = 1'b0;
        w_pipe_en   = 1'b1;
        w_run_rules = 1'b0;
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        err_d       = err_q;

        case (state_q)
            ST_RUN: begin
                w_run_rules = 1'b1;
            end
            ST_LOAD_STALL: begin
                // A memory stall or a (nominally impossible) branch preempts the remaining stall.
                if (w_mem_busy || branch_taken) begin
                    w_run_rules = 1'b1;
                end else begin
                    w_pc_le    = 1'b0;
                    w_if_id_le = 1'b0;
                    w_bubble   = 1'b1;
                    if (stall_cnt_q == 3'd1) begin
                        state_d     = ST_RUN;
                        stall_cnt_d = 3'd0;
                    end else begin
                        stall_cnt_d = stall_cnt_q - 3'd1;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    w_run_rules = 1'b1;
                end else if (tmo_cnt_q == c_TIMEOUT) begin
                    // Give up on the access: release the pipeline this cycle and flag it.
                    err_d     = 1'b1;
                    state_d   = ST_RUN;
                    tmo_cnt_d = 8'd0;
                end else begin
                    w_pc_le    = 1'b0;
                    w_if_id_le = 1'b0;
                    w_pipe_en  = 1'b0;
                    tmo_cnt_d  = tmo_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (w_run_rules) begin
            state_d = ST_RUN;
            if (w_mem_busy) begin
                w_pc_le     = 1'b0;
                w_if_id_le  = 1'b0;
                w_pipe_en   = 1'b0;
                state_d     = ST_MEM_WAIT;
                tmo_cnt_d   = 8'd1;
                stall_cnt_d = 3'd0;
            end else if (branch_taken) begin
                w_flush     = 1'b1;
                w_bubble    = 1'b1;
                stall_cnt_d = 3'd0;
            end else if (w_load_use) begin
                w_pc_le    = 1'b0;
                w_if_id_le = 1'b0;
                w_bubble   = 1'b1;
                if (c_MULTI_STALL) begin
                    state_d     = ST_LOAD_STALL;
                    stall_cnt_d = c_STALL_INIT;
                end
            end
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (!w_pc_le && (stall_count_q != c_CNT_MAX)) begin
            stall_count_d = stall_count_q + c_CNT_ONE;
        end
        if (w_flush && (flush_count_q != c_CNT_MAX)) begin
            flush_count_d = flush_count_q + c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            stall_cnt_q   <= 3'd0;
            tmo_cnt_q     <= 8'd0;
            stall_count_q <= '0;
            flush_count_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            stall_cnt_q   <= stall_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
            err_q         <= err_d;
        end
    end

    // Reset overrides the control outputs combinationally so the pipeline is held at once.
    assign pc_le           = reset ? w_pc_le    : 1'b0;
    assign if_id_le        = reset ? w_if_id_le : 1'b0;
    assign if_id_flush     = reset ? w_flush    : 1'b0;
    assign id_ex_bubble    = reset ? w_bubble   : 1'b1;
    assign pipe_en         = reset ? w_pipe_en  : 1'b0;
    assign stall_count     = stall_count_q;
    assign flush_count     = flush_count_q;
    assign mem_timeout_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// Bench for pipeline_hazard_controller: two instances (3-cycle and 1-cycle load stall)
// driven by directed and random stimulus, checked against a cycle-level reference model.
module tb_pipeline_hazard_controller;

    localparam logic [4:0] c_DEF   = 5'b11001;
    localparam logic [4:0] c_STALL = 5'b00011;
    localparam logic [4:0] c_FRZ   = 5'b00000;
    localparam logic [4:0] c_FLUSH = 5'b11111;
    localparam logic [4:0] c_RST   = 5'b00010;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rw = '0;
    logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_mem_read = 1'b0;
    logic       branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;

    logic       pc_le_a, if_id_le_a, if_id_flush_a, id_ex_bubble_a, pipe_en_a, err_a;
    logic       pc_le_b, if_id_le_b, if_id_flush_b, id_ex_bubble_b, pipe_en_b, err_b;
    logic [4:0] stall_count_a, flush_count_a;
    logic [7:0] stall_count_b, flush_count_b;
    logic [4:0] out_a, out_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(4), .CNT_W(5)) dut_a (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
        .ex_rw(ex_rw), .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_le(pc_le_a), .if_id_le(if_id_le_a), .if_id_flush(if_id_flush_a),
        .id_ex_bubble(id_ex_bubble_a), .pipe_en(pipe_en_a), .stall_count(stall_count_a),
        .flush_count(flush_count_a), .mem_timeout_err(err_a)
    );

    pipeline_hazard_controller #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(6), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
        .ex_rw(ex_rw), .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_le(pc_le_b), .if_id_le(if_id_le_b), .if_id_flush(if_id_flush_b),
        .id_ex_bubble(id_ex_bubble_b), .pipe_en(pipe_en_b), .stall_count(stall_count_b),
        .flush_count(flush_count_b), .mem_timeout_err(err_b)
    );

    assign out_a = {pc_le_a, if_id_le_a, if_id_flush_a, id_ex_bubble_a, pipe_en_a};
    assign out_b = {pc_le_b, if_id_le_b, if_id_flush_b, id_ex_bubble_b, pipe_en_b};

    // Reference model state: remaining forced stall cycles, memory-wait cycle index
    // (0 = not waiting), event counts and the sticky timeout flag.
    int         m_l[2]    = '{3, 1};
    int         m_t[2]    = '{4, 6};
    int         m_max[2]  = '{31, 255};
    int         m_rem[2]  = '{0, 0};
    int         m_wait[2] = '{0, 0};
    int         m_sc[2]   = '{0, 0};
    int         m_fc[2]   = '{0, 0};
    bit         m_err[2]  = '{1'b0, 1'b0};
    logic [4:0] obs[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cmp(input int i, input logic [4:0] act_o, input logic [31:0] act_sc,
                             input logic [31:0] act_fc, input logic act_err);
        logic [4:0] exp_o;
        bit lu, busy, run;
        obs[i] = act_o;
        if (!reset) begin
            m_rem[i] = 0; m_wait[i] = 0; m_sc[i] = 0; m_fc[i] = 0; m_err[i] = 1'b0;
            check($sformatf("rst_outs[%0d]", i), 32'(act_o), 32'(c_RST));
            check($sformatf("rst_stall_cnt[%0d]", i), act_sc, 32'd0);
            check($sformatf("rst_flush_cnt[%0d]", i), act_fc, 32'd0);
            check($sformatf("rst_err[%0d]", i), 32'(act_err), 32'd0);
            return;
        end
        check($sformatf("stall_cnt[%0d]", i), act_sc, 32'(m_sc[i]));
        check($sformatf("flush_cnt[%0d]", i), act_fc, 32'(m_fc[i]));
        check($sformatf("err[%0d]", i), 32'(act_err), 32'(m_err[i]));

        lu = ex_mem_read && (ex_rw != 0) &&
             ((id_uses_rs && id_rs == ex_rw) || (id_uses_rt && id_rt == ex_rw));
        busy  = dmem_req && !dmem_ready;
        run   = 1'b1;
        exp_o = c_DEF;
        if (m_wait[i] > 0) begin
            run = 1'b0;
            if (dmem_ready) begin
                m_wait[i] = 0;
                run = 1'b1;
            end else if (m_wait[i] == m_t[i]) begin
                exp_o = c_DEF; m_err[i] = 1'b1; m_wait[i] = 0;
            end else begin
                exp_o = c_FRZ; m_wait[i]++;
            end
        end
        if (run) begin
            if (busy) begin
                exp_o = c_FRZ; m_wait[i] = 1; m_rem[i] = 0;
            end else if (branch_taken) begin
                exp_o = c_FLUSH; m_rem[i] = 0;
            end else if (m_rem[i] > 0) begin
                exp_o = c_STALL; m_rem[i]--;
            end else if (lu) begin
                exp_o = c_STALL; m_rem[i] = m_l[i] - 1;
            end else begin
                exp_o = c_DEF;
            end
        end
        check($sformatf("outs[%0d]", i), 32'(act_o), 32'(exp_o));
        if (!exp_o[4] && m_sc[i] < m_max[i]) m_sc[i]++;
        if (exp_o[2] && m_fc[i] < m_max[i]) m_fc[i]++;
    endtask

    task automatic tick();
        @(negedge clk);
        model_cmp(0, out_a, 32'(stall_count_a), 32'(flush_count_a), err_a);
        model_cmp(1, out_b, 32'(stall_count_b), 32'(flush_count_b), err_b);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = '0; id_rt = '0; ex_rw = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1'b1; ex_rw = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    endtask

    initial begin
        idle();
        do_reset();
        check("reset_outs_lit", 32'(obs[0]), 32'(c_RST));

        // Single load-use pulse: 3 stall cycles on A, 1 on B.
        set_load_use();
        tick();
        check("lu_b_cycle0", 32'(obs[1]), 32'(c_STALL));
        check("lu_a_cycle0", 32'(obs[0]), 32'(c_STALL));
        idle();
        tick();
        check("lu_b_cycle1", 32'(obs[1]), 32'(c_DEF));
        check("lu_a_cycle1", 32'(obs[0]), 32'(c_STALL));
        tick();
        check("lu_a_cycle2", 32'(obs[0]), 32'(c_STALL));
        tick();
        check("lu_a_cycle3", 32'(obs[0]), 32'(c_DEF));
        check("lu_b_stall_count", 32'(stall_count_b), 32'd1);
        check("lu_a_stall_count", 32'(stall_count_a), 32'd3);

        // No hazard on r0 or on an unused rt field.
        do_reset();
        ex_mem_read = 1'b1; ex_rw = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        tick();
        check("r0_no_stall", 32'(obs[1]), 32'(c_DEF));
        ex_rw = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b0; id_uses_rs = 1'b0; id_rs = 5'd3;
        tick();
        check("rt_unused_no_stall", 32'(obs[0]), 32'(c_DEF));
        check("no_stall_count", 32'(stall_count_b), 32'd0);

        // Branch wins over a simultaneous load-use.
        do_reset();
        set_load_use();
        branch_taken = 1'b1;
        tick();
        check("br_lu_a", 32'(obs[0]), 32'(c_FLUSH));
        check("br_lu_b", 32'(obs[1]), 32'(c_FLUSH));
        idle();
        tick();
        check("br_flush_count", 32'(flush_count_a), 32'd1);
        check("br_stall_count", 32'(stall_count_a), 32'd0);

        // Five-cycle memory wait on B with a branch pulse that must be ignored.
        do_reset();
        dmem_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            branch_taken = (k == 2);
            tick();
            check($sformatf("memwait_b_k%0d", k), 32'(obs[1]), 32'(c_FRZ));
        end
        branch_taken = 1'b0;
        dmem_ready = 1'b1;
        tick();
        check("memwait_b_release", 32'(obs[1]), 32'(c_DEF));
        check("memwait_b_stall_count", 32'(stall_count_b), 32'd5);
        check("memwait_b_flush_count", 32'(flush_count_b), 32'd0);
        idle();
        tick();

        // Timeout on A (MEM_TIMEOUT=4).
        do_reset();
        dmem_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("tmo_a_frozen_k%0d", k), 32'(obs[0]), 32'(c_FRZ));
        end
        tick();
        check("tmo_a_release", 32'(obs[0]), 32'(c_DEF));
        check("tmo_a_err", 32'(err_a), 32'd1);
        check("tmo_a_stall_count", 32'(stall_count_a), 32'd4);
        idle();
        tick();

        // Reset asserted in the middle of a wait takes effect immediately.
        do_reset();
        dmem_req = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("midwait_rst_outs", 32'(out_a), 32'(c_RST));
        check("midwait_rst_stall_count", 32'(stall_count_a), 32'd0);
        tick();
        reset = 1'b1;
        idle();

        // Randomized traffic with rare resets.
        for (int n = 0; n < 4000; n++) begin
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            ex_rw        = 5'($urandom_range(0, 3));
            id_uses_rs   = 1'($urandom_range(0, 1));
            id_uses_rt   = 1'($urandom_range(0, 1));
            ex_mem_read  = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 9) == 0);
            dmem_req     = ($urandom_range(0, 3) == 0);
            dmem_ready   = 1'($urandom_range(0, 1));
            reset        = ($urandom_range(0, 499) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
